if_fetch_ctrl: RTL and testbench

- Instruction-fetch controller between the PC register and the decode stage.
- Takes the current PC value (Address) and runs a req/ack read transaction to instruction memory.
- Latches the returned instruction with its PC into an output holding register.
- Drives the next-PC value into the PC register's R input: PC+step on a completed fetch, redirect target on branch/jump, otherwise hold.

---
 rtl/if_fetch_ctrl_pkg.sv | 19 +
 rtl/if_hold_reg.sv | 64 ++++++
 rtl/if_fetch_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_if_fetch_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl_pkg
//   Shared definitions for the instruction-fetch controller:
//     - fetch_state_e : FSM state encoding (IDLE / REQ / HOLD)
//     - PC_STEP_DEF   : default PC increment per completed fetch
//     - RST_VEC       : reset value of the registered memory address
// ----------------------------------------------------------------------------
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam int          PC_STEP_DEF = 4;
    localparam logic [63:0] RST_VEC     = 64'h0;

endpackage

// File: rtl/if_hold_reg.sv
// ----------------------------------------------------------------------------
// if_hold_reg
//   Output holding register between fetch and decode: instruction, its PC
//   and a valid bit. load captures new data and sets valid; clr drops valid
//   only (data is left in place, it is meaningless once valid is low).
//
// Ports:
//   Clk, Reset      clock, asynchronous active-low reset
//   load            capture instr_in/pc_in, set valid
//   clr             clear valid
//   instr_in, pc_in data to capture
//   valid, instr, pc registered outputs
// ----------------------------------------------------------------------------
module if_hold_reg
    import if_fetch_ctrl_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          load,
    input  logic          clr,
    input  logic [DW-1:0] instr_in,
    input  logic [AW-1:0] pc_in,
    output logic          valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc
);

    logic          valid_d, valid_q;
    logic [DW-1:0] instr_d, instr_q;
    logic [AW-1:0] pc_d,    pc_q;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (load) begin
            valid_d = 1'b1;
            instr_d = instr_in;
            pc_d    = pc_in;
        end else if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// if_fetch_ctrl
//   Instruction-fetch controller between the PC register and decode.
//   Issues one req/ack read per PC value, latches the returned instruction
//   and its PC into an output holding register, and computes the next PC
//   (redirect target, PC+PC_STEP on a completed fetch, else hold).
//
// Ports:
//   Clk, Reset            clock, asynchronous active-low reset
//   Address               current PC from the PC register
//   NPC                   next PC to the PC register R input (combinational)
//   redirect, redirect_target  branch/jump taken and its destination
//   imem_req, imem_addr   registered memory read request / address
//   imem_ack, imem_rdata  one-cycle read-valid pulse and instruction data
//   if_valid, if_instr, if_pc  instruction handed to decode
//   if_ready              decode accepts this cycle
//   fetch_err             (FETCH_TIMEOUT_EN only) sticky ack-timeout flag
//
// Build option:
//   FETCH_TIMEOUT_EN      adds an ack-wait counter; after TIMEOUT cycles in
//                         REQ without ack, fetch_err sets and the fetch is
//                         retried from IDLE.
// ----------------------------------------------------------------------------
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int PC_STEP = PC_STEP_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] Address,
    output logic [AW-1:0] NPC,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_target,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
`ifdef FETCH_TIMEOUT_EN
    output logic          fetch_err,
`endif
    output logic          if_valid,
    input  logic          if_ready,
    output logic [DW-1:0] if_instr,
    output logic [AW-1:0] if_pc
);

    fetch_state_e  state_d, state_q;
    logic          imem_req_d, imem_req_q;
    logic [AW-1:0] imem_addr_d, imem_addr_q;
    // kill marks an in-flight read whose data must be dropped because a
    // redirect arrived while waiting for ack; the bus read cannot be aborted.
    logic          kill_d, kill_q;
    logic          hold_load, hold_clr;
    logic          accept;

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt_d, wait_cnt_q;
    logic          fetch_err_d, fetch_err_q;
`endif

    assign accept = (state_q == REQ) && imem_ack && !kill_q;

    always_comb begin
        if (redirect)
            NPC = redirect_target;
        else if (accept)
            NPC = Address + AW'(PC_STEP);
        else
            NPC = Address;
    end

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        kill_d      = kill_q;
        hold_load   = 1'b0;
        hold_clr    = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
        fetch_err_d = fetch_err_q;
`endif
        case (state_q)
            IDLE: begin
                // A redirect this cycle means Address is stale; wait for the
                // PC register to load the target before requesting.
                if (!redirect) begin
                    imem_req_d  = 1'b1;
                    imem_addr_d = Address;
                    state_d     = REQ;
`ifdef FETCH_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end
            end
            REQ: begin
                if (imem_ack) begin
                    imem_req_d = 1'b0;
                    kill_d     = 1'b0;
                    if (kill_q || redirect) begin
                        state_d = IDLE;
                    end else begin
                        hold_load = 1'b1;
                        state_d   = HOLD;
                    end
                end else begin
                    if (redirect)
                        kill_d = 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                        fetch_err_d = 1'b1;
                        imem_req_d  = 1'b0;
                        kill_d      = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
`endif
                end
            end
            HOLD: begin
                // Redirect squashes the held instruction; either way the
                // holding register empties and a new fetch starts from IDLE.
                if (redirect || if_ready) begin
                    hold_clr = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RST_VEC[AW-1:0];
            kill_q      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            kill_q      <= kill_d;
`ifdef FETCH_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
            fetch_err_q <= fetch_err_d;
`endif
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err = fetch_err_q;
`endif

    if_hold_reg #(
        .AW (AW),
        .DW (DW)
    ) u_hold (
        .Clk      (Clk),
        .Reset    (Reset),
        .load     (hold_load),
        .clr      (hold_clr),
        .instr_in (imem_rdata),
        .pc_in    (imem_addr_q),
        .valid    (if_valid),
        .instr    (if_instr),
        .pc       (if_pc)
    );

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_ctrl
//   Self-checking bench for if_fetch_ctrl. The bench plays the PC register
//   (Address follows NPC each cycle unless a step overrides it) and keeps a
//   transaction-level reference: one outstanding read (busy/doomed), one
//   held instruction (have), next PC from the redirect/accept/hold rules.
// ----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Address;
    logic [31:0] NPC;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
`ifdef FETCH_TIMEOUT_EN
    logic        fetch_err;
`endif

    int ncmp = 0;
    int nerr = 0;

    // reference model
    bit          m_busy, m_doom, m_have;
    logic [31:0] m_bus, m_instr, m_pc, m_npc;

    always #5 Clk = ~Clk;

    if_fetch_ctrl dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Address         (Address),
        .NPC             (NPC),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
`ifdef FETCH_TIMEOUT_EN
        .fetch_err       (fetch_err),
`endif
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
    );

    task automatic ck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] b(input logic x);
        return {31'b0, x};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_doom = 0; m_have = 0;
        m_bus = 0; m_instr = 0; m_pc = 0;
    endtask

    // Apply one cycle of inputs, let them settle, check against the model.
    task automatic drive(input bit rd, input logic [31:0] tg, input bit ak,
                         input logic [31:0] rdat, input bit rdy);
        redirect = rd; redirect_target = tg; imem_ack = ak;
        imem_rdata = rdat; if_ready = rdy;
        #1;
        if (rd)                          m_npc = tg;
        else if (m_busy && ak && !m_doom) m_npc = Address + 32'd4;
        else                             m_npc = Address;
        ck("npc",   NPC,         m_npc);
        ck("req",   b(imem_req), b(m_busy));
        ck("iaddr", imem_addr,   m_bus);
        ck("valid", b(if_valid), b(m_have));
        if (m_have) begin
            ck("instr", if_instr, m_instr);
            ck("pc",    if_pc,    m_pc);
        end
    endtask

    // Advance the model across the clock edge, then let the PC register load NPC.
    task automatic tick();
        if (m_busy) begin
            if (imem_ack) begin
                m_busy = 0;
                if (!m_doom && !redirect) begin
                    m_have = 1; m_instr = imem_rdata; m_pc = m_bus;
                end
                m_doom = 0;
            end else if (redirect) begin
                m_doom = 1;
            end
        end else if (m_have) begin
            if (redirect || if_ready) m_have = 0;
        end else if (!redirect) begin
            m_busy = 1; m_bus = Address;
        end
        @(posedge Clk);
        @(negedge Clk);
        Address = m_npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; Address = 32'h0; redirect = 0; redirect_target = 0;
        imem_ack = 0; imem_rdata = 0; if_ready = 0;
        model_reset();
        #2;
        ck("rst_req",   b(imem_req), 32'h0);
        ck("rst_iaddr", imem_addr,   32'h0);
        ck("rst_valid", b(if_valid), 32'h0);
        ck("rst_instr", if_instr,    32'h0);
        ck("rst_pc",    if_pc,       32'h0);
        @(negedge Clk);
        Reset = 1'b1;

        // single fetch at 0x100
        Address = 32'h100;
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0);
        ck("sf_iaddr", imem_addr, 32'h100);
        ck("sf_req",   b(imem_req), 32'h1);
        tick();
        drive(0, 0, 1, 32'hDEADBEEF, 0);
        ck("sf_npc", NPC, 32'h104);
        tick();
        drive(0, 0, 0, 0, 0);
        ck("sf_instr", if_instr, 32'hDEADBEEF);
        ck("sf_pc",    if_pc,    32'h100);
        ck("sf_hold",  NPC,      32'h104);

        // backpressure: stray acks in HOLD must be ignored
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, $urandom, 0);
            ck("bp_instr", if_instr, 32'hDEADBEEF);
            ck("bp_noreq", b(imem_req), 32'h0);
            tick();
        end
        drive(0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0);
        ck("bp_idle", b(if_valid), 32'h0);
        tick();

        // redirect while waiting for ack
        drive(1, 32'h400, 0, 0, 0);
        ck("rd_npc", NPC, 32'h400);
        tick();
        drive(0, 0, 1, 32'h12345678, 0);
        ck("rd_nostep", NPC, 32'h400);
        tick();
        drive(0, 0, 0, 0, 0);
        ck("rd_drop", b(if_valid), 32'h0);
        tick();
        drive(0, 0, 0, 0, 0);
        ck("rd_iaddr", imem_addr, 32'h400);
        tick();
        drive(0, 0, 1, 32'hCAFE0001, 0); tick();

        // redirect and ready together in HOLD
        drive(1, 32'h800, 0, 0, 1);
        ck("rh_npc", NPC, 32'h800);
        tick();
        drive(1, 32'h900, 0, 0, 0);
        ck("rh_valid", b(if_valid), 32'h0);
        ck("rh_noreq", b(imem_req), 32'h0);
        tick();

        // PC wrap
        Address = 32'hFFFFFFFC;
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 32'h0000ABCD, 0);
        ck("wrap_npc", NPC, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1);
        ck("wrap_pc", if_pc, 32'hFFFFFFFC);
        tick();
        drive(0, 0, 0, 0, 0); tick();

        // asynchronous reset with a read in flight
        drive(0, 0, 0, 0, 0);
        Reset = 1'b0;
        #1;
        ck("ar_req",   b(imem_req), 32'h0);
        ck("ar_valid", b(if_valid), 32'h0);
        ck("ar_iaddr", imem_addr,   32'h0);
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        Address = 32'h200;

        // randomized traffic with the bench acting as PC register
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) == 0, $urandom & 32'hFFFFFFFC,
                  $urandom_range(0, 2) == 0, $urandom, $urandom_range(0, 1) == 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
